frame_column_loader: RTL and testbench

- Upstream configuration stage for one fabric column. It sits below the bottom terminal tile of the column and drives that tile's FrameData and FrameStrobe inputs.
- Accepts a 32-bit configuration word stream over a valid/ready handshake. Detects a sync word, then parses frame headers and per-row data words.
- Assembles the row-parallel frame data register, then issues a one-cycle strobe on the addressed frame line for this column.

---
 rtl/frame_column_loader.sv | 142 ++++++++++++++
 tb/tb_frame_column_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_column_loader.sv
// Configuration loader for one fabric column: syncs on a marker word, parses frame
// headers, assembles row-parallel frame data and pulses the addressed frame strobe.
module frame_column_loader #(
  parameter int          FrameBitsPerRow = 32,
  parameter int          MaxFramesPerCol = 20,
  parameter int          NumberOfRows    = 4,
  parameter int          ColSelectWidth  = 5,
  parameter int          ColIndex        = 0,
  parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
  input  logic                                    CLK,
  input  logic                                    reset,
  input  logic [31:0]                             WriteData,
  input  logic                                    WriteStrobe,
  output logic                                    WriteReady,
  output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]              FrameStrobe,
  output logic                                    Synced,
  output logic                                    FrameError
);

  localparam int                        RowW   = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam logic [ColSelectWidth-1:0] ColSel = ColSelectWidth'(ColIndex);
  localparam logic [7:0]                MaxIdx = 8'(MaxFramesPerCol);

  typedef enum logic [1:0] {IDLE, HDR, DATA, STROBE} state_t;

  state_t                      state_reg, state_next;
  logic [RowW-1:0]             row_reg, row_next;
  logic [ColSelectWidth-1:0]   col_reg, col_next;
  logic [7:0]                  frame_idx_reg, frame_idx_next;
  logic                        synced_reg, synced_next;
  logic                        error_reg, error_next;
  logic [MaxFramesPerCol-1:0]  strobe_reg, strobe_next;
  logic [MaxFramesPerCol-1:0]  frame_hit;
  logic [NumberOfRows-1:0]     row_we;
  logic [FrameBitsPerRow-1:0]  rows_reg [NumberOfRows];
  logic                        accept;
  logic                        last_row;
  logic                        frame_ok;

  assign WriteReady  = (state_reg != STROBE);
  assign accept      = WriteStrobe && WriteReady;
  assign last_row    = (row_reg == RowW'(NumberOfRows - 1));
  assign frame_ok    = (col_reg == ColSel) && (frame_idx_reg < MaxIdx);
  assign FrameStrobe = strobe_reg;
  assign Synced      = synced_reg;
  assign FrameError  = error_reg;

  genvar gi;
  generate
    for (gi = 0; gi < MaxFramesPerCol; gi++) begin : g_hit
      assign frame_hit[gi] = (frame_idx_reg == 8'(gi));
    end

    // Each row keeps its word until a later frame rewrites that row.
    for (gi = 0; gi < NumberOfRows; gi++) begin : g_row
      assign row_we[gi] = accept && (state_reg == DATA) && (row_reg == RowW'(gi));
      assign FrameData[gi*FrameBitsPerRow +: FrameBitsPerRow] = rows_reg[gi];

      always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
          rows_reg[gi] <= '0;
        end else if (row_we[gi]) begin
          rows_reg[gi] <= WriteData[FrameBitsPerRow-1:0];
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      row_reg       <= '0;
      col_reg       <= '0;
      frame_idx_reg <= '0;
      synced_reg    <= 1'b0;
      error_reg     <= 1'b0;
      strobe_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      row_reg       <= row_next;
      col_reg       <= col_next;
      frame_idx_reg <= frame_idx_next;
      synced_reg    <= synced_next;
      error_reg     <= error_next;
      strobe_reg    <= strobe_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    row_next       = row_reg;
    col_next       = col_reg;
    frame_idx_next = frame_idx_reg;
    synced_next    = synced_reg;
    error_next     = error_reg;
    strobe_next    = '0;
    case (state_reg)
      IDLE: begin
        if (accept && (WriteData == SyncWord)) begin
          synced_next = 1'b1;
          error_next  = 1'b0;
          state_next  = HDR;
        end
      end
      HDR: begin
        if (accept) begin
          if (WriteData[31]) begin
            synced_next = 1'b0;
            state_next  = IDLE;
          end else begin
            col_next       = WriteData[16 +: ColSelectWidth];
            frame_idx_next = WriteData[7:0];
            row_next       = '0;
            state_next     = DATA;
            if (WriteData[7:0] >= MaxIdx) begin
              error_next = 1'b1;
            end
          end
        end
      end
      DATA: begin
        if (accept) begin
          row_next = row_reg + 1'b1;
          if (last_row) begin
            // Strobe is registered so it lines up with the single STROBE cycle.
            strobe_next = frame_ok ? frame_hit : '0;
            state_next  = STROBE;
          end
        end
      end
      STROBE: begin
        state_next = HDR;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_frame_column_loader.sv
// Bench for frame_column_loader: directed test-plan steps followed by a random
// stream, all checked against a word-level reference model of the loader.
module tb_frame_column_loader;

  localparam int          NR   = 4;
  localparam int          MF   = 20;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic         CLK = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  WriteData = '0;
  logic         WriteStrobe = 1'b0;
  logic         WriteReady;
  logic [127:0] FrameData;
  logic [19:0]  FrameStrobe;
  logic         Synced;
  logic         FrameError;

  always #5 CLK = ~CLK;

  frame_column_loader #(
    .FrameBitsPerRow(32),
    .MaxFramesPerCol(MF),
    .NumberOfRows(NR),
    .ColSelectWidth(5),
    .ColIndex(0),
    .SyncWord(SYNC)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .WriteData(WriteData),
    .WriteStrobe(WriteStrobe),
    .WriteReady(WriteReady),
    .FrameData(FrameData),
    .FrameStrobe(FrameStrobe),
    .Synced(Synced),
    .FrameError(FrameError)
  );

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int strobe_times[$];
  logic [19:0] strobe_vals[$];

  // Reference model: word-level view of the stream protocol.
  bit          m_synced, m_err, m_in_data, m_in_strobe, last_acc;
  int          m_k, m_col, m_idx;
  logic [31:0] m_rows [NR];
  logic [19:0] m_strobe;

  function automatic logic [127:0] m_data();
    return {m_rows[3], m_rows[2], m_rows[1], m_rows[0]};
  endfunction

  task automatic m_reset();
    m_synced = 0; m_err = 0; m_in_data = 0; m_in_strobe = 0;
    m_k = 0; m_col = 0; m_idx = 0; m_strobe = '0;
    for (int i = 0; i < NR; i++) m_rows[i] = '0;
  endtask

  task automatic m_edge(input bit s, input logic [31:0] w);
    bit acc;
    acc = s && !m_in_strobe;
    last_acc = acc;
    m_strobe = '0;
    if (m_in_strobe) begin
      m_in_strobe = 0;
    end else if (acc) begin
      if (!m_synced) begin
        if (w == SYNC) begin
          m_synced = 1;
          m_err = 0;
        end
      end else if (!m_in_data) begin
        if (w[31]) begin
          m_synced = 0;
        end else begin
          m_col = int'(w[20:16]);
          m_idx = int'(w[7:0]);
          m_k = 0;
          m_in_data = 1;
          if (m_idx >= MF) m_err = 1;
        end
      end else begin
        m_rows[m_k] = w;
        m_k++;
        if (m_k == NR) begin
          m_in_data = 0;
          m_in_strobe = 1;
          if (m_col == 0 && m_idx < MF) m_strobe = 20'(1) << m_idx;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic cycle(input bit s, input logic [31:0] w);
    @(negedge CLK);
    WriteStrobe = s;
    WriteData = w;
    #1;
    chk("ready", WriteReady, !m_in_strobe);
    @(posedge CLK);
    m_edge(s, w);
    cyc++;
    #1;
    chk("synced", Synced, m_synced);
    chk("frame_error", FrameError, m_err);
    chk("frame_strobe", FrameStrobe, m_strobe);
    chk("frame_data", FrameData, m_data());
    if (FrameStrobe != '0) begin
      strobe_times.push_back(cyc);
      strobe_vals.push_back(FrameStrobe);
    end
    $display("cyc %0d ws=%0b wd=%h acc=%0b synced=%0b err=%0b strobe=%h", cyc, s, w,
             last_acc, Synced, FrameError, FrameStrobe);
  endtask

  task automatic send(input logic [31:0] w);
    for (int t = 0; t < 4; t++) begin
      cycle(1'b1, w);
      if (last_acc) break;
    end
    chk("send_accepted", last_acc, 1'b1);
  endtask

  task automatic send_frame(input logic [31:0] hdr, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3);
    send(hdr); send(d0); send(d1); send(d2); send(d3);
  endtask

  initial begin
    logic [31:0] w;
    int r;
    m_reset();

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", WriteReady, 1'b1);
    chk("rst_data", FrameData, 128'h0);
    chk("rst_strobe", FrameStrobe, 20'h0);
    chk("rst_synced", Synced, 1'b0);
    chk("rst_error", FrameError, 1'b0);
    @(negedge CLK);
    reset = 1'b0;

    // Basic frame to index 3
    send(SYNC);
    chk("tp1_synced", Synced, 1'b1);
    send_frame(32'h0000_0003, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    chk("tp1_strobe", FrameStrobe, 20'h00008);
    chk("tp1_ready_low", WriteReady, 1'b0);
    chk("tp1_data", FrameData, 128'h44444444_33333333_22222222_11111111);
    cycle(1'b0, 32'h0);
    chk("tp1_strobe_once", FrameStrobe, 20'h0);

    // Column mismatch
    send_frame(32'h0001_0005, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888);
    chk("tp2_no_strobe", FrameStrobe, 20'h0);
    chk("tp2_error", FrameError, 1'b0);
    chk("tp2_data", FrameData, 128'h88888888_77777777_66666666_55555555);
    cycle(1'b0, 32'h0);

    // Out-of-range frame index, then desync/resync
    send(32'h0000_0019);
    chk("tp3_error_set", FrameError, 1'b1);
    send(32'hA0A0A0A0); send(32'hA1A1A1A1); send(32'hA2A2A2A2); send(32'hA3A3A3A3);
    chk("tp3_no_strobe", FrameStrobe, 20'h0);
    send(32'h8000_0000);
    chk("tp3_desync", Synced, 1'b0);
    send(SYNC);
    chk("tp3_resync", Synced, 1'b1);
    chk("tp3_error_clr", FrameError, 1'b0);

    // Stalls inside the data phase
    send(32'h0000_0002);
    send(32'h11111111);
    send(32'h22222222);
    repeat (3) cycle(1'b0, 32'hDEADBEEF);
    send(32'h33333333);
    send(32'h44444444);
    chk("tp4_strobe", FrameStrobe, 20'h00004);
    chk("tp4_data", FrameData, 128'h44444444_33333333_22222222_11111111);

    // Asynchronous reset mid-frame
    send(32'h0000_0001);
    send(32'h99999999);
    send(32'hAAAAAAAA);
    #2;
    reset = 1'b1;
    #1;
    m_reset();
    chk("tp5_data", FrameData, 128'h0);
    chk("tp5_synced", Synced, 1'b0);
    chk("tp5_strobe", FrameStrobe, 20'h0);
    chk("tp5_error", FrameError, 1'b0);
    chk("tp5_ready", WriteReady, 1'b1);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    send(32'h0000_0001);
    send(32'h12345678); send(32'h9ABCDEF0); send(32'h0F0F0F0F); send(32'hF0F0F0F0);
    chk("tp5_unsynced", Synced, 1'b0);

    // Back-to-back frames 0 and 19
    send(SYNC);
    strobe_times.delete();
    strobe_vals.delete();
    send_frame(32'h0000_0000, 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404);
    send_frame(32'h0000_0013, 32'h05050505, 32'h06060606, 32'h07070707, 32'h08080808);
    cycle(1'b0, 32'h0);
    chk("tp6_pulses", strobe_times.size(), 2);
    if (strobe_times.size() >= 2) begin
      chk("tp6_spacing", strobe_times[1] - strobe_times[0], 6);
      chk("tp6_first", strobe_vals[0], 20'h00001);
      chk("tp6_second", strobe_vals[1], 20'h80000);
    end

    // Random stream
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      w = $urandom;
      if (!m_synced) begin
        if (r < 40) w = SYNC;
      end else if (!m_in_data && !m_in_strobe) begin
        if (r < 8) begin
          w[31] = 1'b1;
        end else begin
          w[31] = 1'b0;
          w[20:16] = 5'($urandom_range(0, 1));
          w[7:0] = 8'($urandom_range(0, 24));
        end
      end
      cycle($urandom_range(0, 3) != 0, w);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
